// File: rtl/alu_op_seq.sv
// alu_op_seq: sequences one ALU opcode per accepted start across the shared
// register-select bus, the ALU input latches, the ALU control, the ALU output
// register and register write-back.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start               request, honoured only in IDLE or BUS
//   opCode/para1/para2  opcode and register selects, captured on accepted start
//   busy/done/err       handshake: busy in every non-IDLE state, done in BUS,
//                       err one cycle after a start with para1 all-ones
//   paraOut             register select driven onto the bus (all-ones = none)
//   aluIn1/aluIn2       ALU input latch enables
//   control             ALU control
//   aluOutRegIn/Out     ALU output register latch enable / bus drive
//   regIn               register write-enable select (all-ones = none)
//   incr/fetch          PC increment / instruction-fetch request
//
// state  | meaning
// IDLE   | waiting for start
// OUT1   | operand-1 select on bus, PC increment
// LAT1   | ALU input-1 latched
// OUT2   | operand-2 select on bus (binary ops only)
// LAT2   | ALU input-2 latched (binary ops only)
// CTRL   | ALU control issued
// HOLD   | ALU control held for ALU_LAT cycles
// OUTREG | ALU result latched into output register
// BUS    | result write-back, fetch, done; may chain straight into OUT1
module alu_op_seq #(
    parameter int              SEL_W      = 6,
    parameter int              OP_W       = 4,
    parameter int              ALU_LAT    = 2,
    parameter logic [15:0]     UNARY_MASK = 16'h0000,
    parameter logic [15:0]     NOWB_MASK  = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  opCode,
    input  logic [SEL_W-1:0] para1,
    input  logic [SEL_W-1:0] para2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SEL_W-1:0] paraOut,
    output logic             aluIn1,
    output logic             aluIn2,
    output logic [OP_W-1:0]  control,
    output logic             aluOutRegIn,
    output logic             aluOutRegOut,
    output logic [SEL_W-1:0] regIn,
    output logic             incr,
    output logic             fetch
);

    if (ALU_LAT < 1 || ALU_LAT > 16) begin : gBadLat
        $error("alu_op_seq: ALU_LAT must be within 1..16");
    end

    localparam int               CNT_W = 5;
    localparam logic [SEL_W-1:0] NONE  = '1;

    typedef enum logic [3:0] {
        IDLE, OUT1, LAT1, OUT2, LAT2, CTRL, HOLD, OUTREG, BUS
    } state_t;

    state_t           state, stateNext;
    logic [SEL_W-1:0] op1, op2, op1Next, op2Next;
    logic [OP_W-1:0]  opc, opcNext;
    logic [CNT_W-1:0] holdCnt, holdCntNext;
    logic             canStart, accept, reject;

    // Opcodes beyond the 16 mask bits have no flag set.
    function automatic logic maskBit(input logic [15:0] mask, input logic [OP_W-1:0] op);
        if ((op >> 4) != '0) return 1'b0;
        return mask[4'(op)];
    endfunction

    always_comb begin
        stateNext   = state;
        op1Next     = op1;
        op2Next     = op2;
        opcNext     = opc;
        holdCntNext = holdCnt;
        canStart    = (state == IDLE) || (state == BUS);
        accept      = canStart && start && (para1 != NONE);
        reject      = canStart && start && (para1 == NONE);

        case (state)
            IDLE:   if (accept) stateNext = OUT1;
            OUT1:   stateNext = LAT1;
            LAT1:   stateNext = maskBit(UNARY_MASK, opc) ? CTRL : OUT2;
            OUT2:   stateNext = LAT2;
            LAT2:   stateNext = CTRL;
            CTRL: begin
                stateNext   = HOLD;
                holdCntNext = CNT_W'(ALU_LAT - 1);
            end
            HOLD: begin
                if (holdCnt == '0) stateNext = OUTREG;
                else holdCntNext = holdCnt - 1'b1;
            end
            OUTREG: stateNext = BUS;
            BUS:    stateNext = accept ? OUT1 : IDLE;
            default: stateNext = IDLE;
        endcase

        if (accept) begin
            op1Next = para1;
            op2Next = para2;
            opcNext = opCode;
        end
    end

    // Outputs are registered from the next state and next captured values,
    // so they always match the decode of the present state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            holdCnt      <= '0;
            op1          <= '0;
            op2          <= '0;
            opc          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            paraOut      <= NONE;
            aluIn1       <= 1'b0;
            aluIn2       <= 1'b0;
            control      <= '0;
            aluOutRegIn  <= 1'b0;
            aluOutRegOut <= 1'b0;
            regIn        <= NONE;
            incr         <= 1'b0;
            fetch        <= 1'b0;
        end else begin
            state        <= stateNext;
            holdCnt      <= holdCntNext;
            op1          <= op1Next;
            op2          <= op2Next;
            opc          <= opcNext;
            busy         <= (stateNext != IDLE);
            err          <= reject;
            done         <= 1'b0;
            paraOut      <= NONE;
            aluIn1       <= 1'b0;
            aluIn2       <= 1'b0;
            control      <= '0;
            aluOutRegIn  <= 1'b0;
            aluOutRegOut <= 1'b0;
            regIn        <= NONE;
            incr         <= 1'b0;
            fetch        <= 1'b0;
            case (stateNext)
                OUT1: begin
                    paraOut <= op1Next;
                    incr    <= 1'b1;
                end
                LAT1: begin
                    paraOut <= op1Next;
                    aluIn1  <= 1'b1;
                end
                OUT2:   paraOut <= op2Next;
                LAT2: begin
                    paraOut <= op2Next;
                    aluIn2  <= 1'b1;
                end
                CTRL, HOLD: control <= opcNext;
                OUTREG: aluOutRegIn <= 1'b1;
                BUS: begin
                    done  <= 1'b1;
                    fetch <= 1'b1;
                    if (!maskBit(NOWB_MASK, opcNext)) begin
                        aluOutRegOut <= 1'b1;
                        regIn        <= op1Next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_seq.sv
module tb_alu_op_seq;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [5:0] paraOut;
        logic       aluIn1;
        logic       aluIn2;
        logic [3:0] control;
        logic       aluOutRegIn;
        logic       aluOutRegOut;
        logic [5:0] regIn;
        logic       incr;
        logic       fetch;
    } outs_t;

    typedef struct packed {
        int    cyc;
        outs_t v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // dut0: ALU_LAT=2, opcode 7 unary, opcode 9 no-writeback
    logic       rst0, start0;
    logic [3:0] opc0;
    logic [5:0] pA0, pB0;
    logic       busy0, done0, err0, aluIn1_0, aluIn2_0, aoIn0, aoOut0, incr0, fetch0;
    logic [5:0] paraOut0, regIn0;
    logic [3:0] control0;

    // dut1: ALU_LAT=4, opcode 7 unary
    logic       rst1, start1;
    logic [3:0] opc1;
    logic [5:0] pA1, pB1;
    logic       busy1, done1, err1, aluIn1_1, aluIn2_1, aoIn1, aoOut1, incr1, fetch1;
    logic [5:0] paraOut1, regIn1;
    logic [3:0] control1;

    alu_op_seq #(.SEL_W(6), .OP_W(4), .ALU_LAT(2),
                 .UNARY_MASK(16'h0080), .NOWB_MASK(16'h0200)) dut0 (
        .clk(clk), .reset(rst0), .start(start0), .opCode(opc0),
        .para1(pA0), .para2(pB0), .busy(busy0), .done(done0), .err(err0),
        .paraOut(paraOut0), .aluIn1(aluIn1_0), .aluIn2(aluIn2_0),
        .control(control0), .aluOutRegIn(aoIn0), .aluOutRegOut(aoOut0),
        .regIn(regIn0), .incr(incr0), .fetch(fetch0)
    );

    alu_op_seq #(.SEL_W(6), .OP_W(4), .ALU_LAT(4),
                 .UNARY_MASK(16'h0080), .NOWB_MASK(16'h0000)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .opCode(opc1),
        .para1(pA1), .para2(pB1), .busy(busy1), .done(done1), .err(err1),
        .paraOut(paraOut1), .aluIn1(aluIn1_1), .aluIn2(aluIn2_1),
        .control(control1), .aluOutRegIn(aoIn1), .aluOutRegOut(aoOut1),
        .regIn(regIn1), .incr(incr1), .fetch(fetch1)
    );

    outs_t act0, act1;
    assign act0 = {busy0, done0, err0, paraOut0, aluIn1_0, aluIn2_0, control0,
                   aoIn0, aoOut0, regIn0, incr0, fetch0};
    assign act1 = {busy1, done1, err1, paraOut1, aluIn1_1, aluIn2_1, control1,
                   aoIn1, aoOut1, regIn1, incr1, fetch1};

    exp_t  q0[$];
    exp_t  q1[$];
    string n0[$];
    string n1[$];

    function automatic outs_t idleVec();
        outs_t v;
        v = '0;
        v.paraOut = 6'h3F;
        v.regIn   = 6'h3F;
        return v;
    endfunction

    task automatic pushE(input int d, input int c, input outs_t v, input string nm);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        if (d == 0) begin
            q0.push_back(e);
            n0.push_back(nm);
        end else begin
            q1.push_back(e);
            n1.push_back(nm);
        end
    endtask

    task automatic pushIdle(input int d, input int from, input int upto, input string nm);
        for (int c = from; c <= upto; c++) pushE(d, c, idleVec(), nm);
    endtask

    // Expected per-cycle trace of one op, OUT1 visible in cycle s.
    task automatic pushSeq(input int d, input int s, input logic [5:0] o1, input logic [5:0] o2,
                           input logic [3:0] opc, input int lat, input bit unary,
                           input bit nowb, input int maxN, input string nm);
        outs_t seq[$];
        outs_t v;
        v = idleVec(); v.busy = 1; v.paraOut = o1; v.incr = 1;   seq.push_back(v);
        v = idleVec(); v.busy = 1; v.paraOut = o1; v.aluIn1 = 1; seq.push_back(v);
        if (!unary) begin
            v = idleVec(); v.busy = 1; v.paraOut = o2;             seq.push_back(v);
            v = idleVec(); v.busy = 1; v.paraOut = o2; v.aluIn2 = 1; seq.push_back(v);
        end
        v = idleVec(); v.busy = 1; v.control = opc;              seq.push_back(v);
        for (int i = 0; i < lat; i++) seq.push_back(v);
        v = idleVec(); v.busy = 1; v.aluOutRegIn = 1;            seq.push_back(v);
        v = idleVec(); v.busy = 1; v.done = 1; v.fetch = 1;
        if (!nowb) begin
            v.aluOutRegOut = 1;
            v.regIn        = o1;
        end
        seq.push_back(v);
        for (int i = 0; i < seq.size() && i < maxN; i++) pushE(d, s + i, seq[i], nm);
    endtask

    // Scoreboard monitor: compares whenever an expectation is due.
    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].cyc < cyc) begin
            failures++;
            $display("FAIL %s dut0 cyc=%0d expectation never compared", n0[0], q0[0].cyc);
            void'(q0.pop_front()); void'(n0.pop_front());
        end
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            checks++;
            if (act0 !== q0[0].v) begin
                failures++;
                $display("FAIL %s dut0 cyc=%0d actual=%h required=%h", n0[0], cyc, act0, q0[0].v);
            end
            void'(q0.pop_front()); void'(n0.pop_front());
        end
        while (q1.size() > 0 && q1[0].cyc < cyc) begin
            failures++;
            $display("FAIL %s dut1 cyc=%0d expectation never compared", n1[0], q1[0].cyc);
            void'(q1.pop_front()); void'(n1.pop_front());
        end
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            checks++;
            if (act1 !== q1[0].v) begin
                failures++;
                $display("FAIL %s dut1 cyc=%0d actual=%h required=%h", n1[0], cyc, act1, q1[0].v);
            end
            void'(q1.pop_front()); void'(n1.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int s;
        rst0 = 0; start0 = 0; opc0 = 0; pA0 = 0; pB0 = 0;
        rst1 = 0; start1 = 0; opc1 = 0; pA1 = 0; pB1 = 0;
        pushIdle(0, 1, 4, "resetIdle");
        pushIdle(1, 1, 4, "resetIdle");
        tick(2);
        rst0 = 1; rst1 = 1;
        tick(3);

        // binary op, default latency, inputs change right after capture
        k = cyc;
        start0 = 1; opc0 = 4'h1; pA0 = 6'd3; pB0 = 6'd5;
        pushSeq(0, k + 1, 6'd3, 6'd5, 4'h1, 2, 0, 0, 99, "binDef");
        pushIdle(0, k + 10, k + 11, "binDefIdle");
        tick(1);
        start0 = 0; opc0 = 4'h9; pA0 = 6'd7; pB0 = 6'd8;
        tick(12);

        // no-writeback opcode
        k = cyc;
        start0 = 1; opc0 = 4'h9; pA0 = 6'd2; pB0 = 6'd1;
        pushSeq(0, k + 1, 6'd2, 6'd1, 4'h9, 2, 0, 1, 99, "nowb");
        pushIdle(0, k + 10, k + 10, "nowbIdle");
        tick(1);
        start0 = 0;
        tick(11);

        // start held high: back-to-back issue, mid-op input changes ignored
        k = cyc;
        start0 = 1; opc0 = 4'h1; pA0 = 6'd3; pB0 = 6'd5;
        pushSeq(0, k + 1, 6'd3, 6'd5, 4'h1, 2, 0, 0, 99, "b2bFirst");
        pushSeq(0, k + 10, 6'd4, 6'd6, 4'h2, 2, 0, 0, 99, "b2bSecond");
        pushIdle(0, k + 19, k + 19, "b2bIdle");
        tick(1);
        opc0 = 4'h2; pA0 = 6'd4; pB0 = 6'd6;
        tick(9);
        start0 = 0;
        tick(11);

        // rejected start in IDLE
        k = cyc;
        start0 = 1; opc0 = 4'h5; pA0 = 6'h3F; pB0 = 6'd2;
        begin
            outs_t v;
            v = idleVec();
            v.err = 1;
            pushE(0, k + 1, v, "errPulse");
        end
        pushIdle(0, k + 2, k + 3, "errAfter");
        tick(1);
        start0 = 0;
        tick(3);

        // starts during HOLD are ignored, with no err
        k = cyc;
        start0 = 1; opc0 = 4'h3; pA0 = 6'd12; pB0 = 6'd13;
        pushSeq(0, k + 1, 6'd12, 6'd13, 4'h3, 2, 0, 0, 99, "holdIgnore");
        pushIdle(0, k + 10, k + 10, "holdIgnoreIdle");
        tick(1);
        start0 = 0;
        tick(5);
        start0 = 1; pA0 = 6'h3F;
        tick(1);
        pA0 = 6'd20;
        tick(1);
        start0 = 0;
        tick(4);

        // asynchronous reset in the second HOLD cycle
        k = cyc;
        s = k + 1;
        start0 = 1; opc0 = 4'h1; pA0 = 6'd3; pB0 = 6'd5;
        pushSeq(0, s, 6'd3, 6'd5, 4'h1, 2, 0, 0, 6, "rstPre");
        pushIdle(0, s + 6, s + 9, "rstIdle");
        tick(1);
        start0 = 0;
        tick(6);
        rst0 = 0;
        tick(1);
        rst0 = 1;
        tick(4);

        // para1 = 0 is a legal select; binary op after reset
        k = cyc;
        start0 = 1; opc0 = 4'hF; pA0 = 6'd0; pB0 = 6'h3E;
        pushSeq(0, k + 1, 6'd0, 6'h3E, 4'hF, 2, 0, 0, 99, "sel0");
        pushIdle(0, k + 10, k + 10, "sel0Idle");
        tick(1);
        start0 = 0;
        tick(11);

        // unary op with ALU_LAT=4
        k = cyc;
        start1 = 1; opc1 = 4'h7; pA1 = 6'd10; pB1 = 6'd11;
        pushSeq(1, k + 1, 6'd10, 6'd11, 4'h7, 4, 1, 0, 99, "unaryLat4");
        pushIdle(1, k + 10, k + 10, "unaryIdle");
        tick(1);
        start1 = 0;
        tick(11);

        // binary op with ALU_LAT=4
        k = cyc;
        start1 = 1; opc1 = 4'h1; pA1 = 6'd1; pB1 = 6'd2;
        pushSeq(1, k + 1, 6'd1, 6'd2, 4'h1, 4, 0, 0, 99, "binLat4");
        pushIdle(1, k + 12, k + 12, "binLat4Idle");
        tick(1);
        start1 = 0;
        tick(13);

        for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) tick(1);
        if (q0.size() > 0 || q1.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q0.size() + q1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
